// File: rtl/camera_frame_ctrl.sv
// camera_frame_ctrl: frame-level handshake between a camera sensor and the
// capture datapath. Skips a configurable number of frames after START, arms
// capture, holds a captured frame until the consumer is done, then releases
// it (optionally re-arming continuously). Flags missing VSYNC with a timeout.
// Optional build macro: CAMFC_LINE_CHECK_EN enables a per-frame HREF line
// count check that sets LINE_ERR when the captured frame has the wrong size.
module camera_frame_ctrl #(
   parameter int SKIP_FRAMES = 2,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int EXP_LINES   = 240
) (
   input  logic        PCLK,
   input  logic        HRESETn,
   input  logic        VSYNC,
   input  logic        HREF,
   input  logic        START,
   input  logic        ABORT,
   input  logic        CONT,
   input  logic        CAP_READY,
   input  logic        RD_DONE,
   output logic        CAP_VALID,
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic        TIMEOUT_ERR,
   output logic        LINE_ERR,
   output logic [15:0] FRAME_CNT
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SKIP    = 3'd1;
   localparam logic [2:0] ST_ARM     = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [2:0]        state_q, state_d;
   logic              vsync_q, vsync_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [TO_W-1:0]   timeout_q, timeout_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              cap_valid_q, cap_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              timeout_err_q, timeout_err_d;

   logic              vsync_rise;
   logic              to_run;
   logic              to_expire;
   logic              start_accept;
   logic              frame_accept;
   logic [SKIP_W-1:0] skip_inc;

   assign vsync_rise   = VSYNC & ~vsync_q;
   assign to_run       = (state_q == ST_SKIP) || (state_q == ST_ARM);
   // A VSYNC edge restarts the watchdog, so it can never expire on that cycle.
   assign to_expire    = to_run && !vsync_rise && (timeout_q == TO_LAST);
   assign start_accept = (state_q == ST_IDLE) && START;
   assign skip_inc     = skip_q + SKIP_W'(1);

   // Next-state, counters and registered outputs; ABORT outranks everything.
   always_comb begin
      state_d       = state_q;
      vsync_d       = VSYNC;
      skip_d        = skip_q;
      frame_cnt_d   = frame_cnt_q;
      frame_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
      frame_accept  = 1'b0;
      // Watchdog idles at zero outside SKIP/ARM, so every entry starts fresh.
      timeout_d     = (to_run && !vsync_rise) ? timeout_q + TO_W'(1) : '0;

      if (ABORT && (state_q != ST_IDLE)) begin
         state_d = ST_RELEASE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  skip_d        = '0;
                  timeout_err_d = 1'b0;
                  state_d       = (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (to_expire) begin
                  timeout_err_d = 1'b1;
                  state_d       = ST_IDLE;
               end else if (vsync_rise) begin
                  skip_d = skip_inc;
                  if (skip_inc == SKIP_W'(SKIP_FRAMES)) begin
                     state_d = ST_ARM;
                  end
               end
            end
            ST_ARM: begin
               if (to_expire) begin
                  timeout_err_d = 1'b1;
                  state_d       = ST_IDLE;
               end else if (CAP_READY) begin
                  frame_accept = 1'b1;
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  state_d      = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (RD_DONE) begin
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!CAP_READY) begin
                  state_d = CONT ? ST_ARM : ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      cap_valid_d = (state_d == ST_ARM) || (state_d == ST_HOLD);
   end

   // Control registers; reset clears CAP_VALID without waiting for a clock.
   always_ff @(posedge PCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q       <= ST_IDLE;
         vsync_q       <= 1'b0;
         skip_q        <= '0;
         timeout_q     <= '0;
         frame_cnt_q   <= '0;
         cap_valid_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync_d;
         skip_q        <= skip_d;
         timeout_q     <= timeout_d;
         frame_cnt_q   <= frame_cnt_d;
         cap_valid_q   <= cap_valid_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

`ifdef CAMFC_LINE_CHECK_EN
   logic       href_q, href_d;
   logic [9:0] line_q, line_d;
   logic       line_err_q, line_err_d;
   logic       href_rise;

   assign href_rise = HREF & ~href_q;

   // Line counter restarts per frame; the count is judged when a frame is taken.
   always_comb begin
      href_d     = HREF;
      line_d     = line_q;
      line_err_d = line_err_q;
      if (vsync_rise) begin
         line_d = '0;
      end
      if ((state_q == ST_ARM) && href_rise) begin
         line_d = line_d + 10'd1;
      end
      if (start_accept) begin
         line_err_d = 1'b0;
      end else if (frame_accept && (line_q != 10'(EXP_LINES))) begin
         line_err_d = 1'b1;
      end
   end

   // Line check registers.
   always_ff @(posedge PCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         href_q     <= 1'b0;
         line_q     <= '0;
         line_err_q <= 1'b0;
      end else begin
         href_q     <= href_d;
         line_q     <= line_d;
         line_err_q <= line_err_d;
      end
   end

   assign LINE_ERR = line_err_q;
`else
   logic unused_line_cfg;
   assign unused_line_cfg = HREF & start_accept & frame_accept & (EXP_LINES > 0);
   assign LINE_ERR        = 1'b0;
`endif

   assign CAP_VALID   = cap_valid_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign FRAME_DONE  = frame_done_q;
   assign TIMEOUT_ERR = timeout_err_q;
   assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_camera_frame_ctrl.sv
// tb_camera_frame_ctrl: directed plus randomized frame handshakes for
// camera_frame_ctrl, checked against a transaction-level expectation model.
module tb_camera_frame_ctrl;

`ifdef CAMFC_LINE_CHECK_EN
   localparam bit LINE_CHK = 1'b1;
   localparam int TO_CYC   = 600;   // long enough for a full 240-line frame
`else
   localparam bit LINE_CHK = 1'b0;
   localparam int TO_CYC   = 100;
`endif
   localparam int SKIPN = 2;
   localparam int EXPL  = 240;

   logic        PCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        VSYNC = 1'b0, HREF = 1'b0, START = 1'b0, ABORT = 1'b0, CONT = 1'b0;
   logic        CAP_READY = 1'b0, RD_DONE = 1'b0;
   logic        CAP_VALID, BUSY, FRAME_DONE, TIMEOUT_ERR, LINE_ERR;
   logic [15:0] FRAME_CNT;

   int errors = 0;
   int checks = 0;

   // Expectation model: completed-frame count and sticky error flags.
   logic [15:0] m_cnt  = 16'd0;
   logic        m_terr = 1'b0;
   logic        m_lerr = 1'b0;

   camera_frame_ctrl #(
      .SKIP_FRAMES (SKIPN),
      .TIMEOUT_CYC (TO_CYC),
      .EXP_LINES   (EXPL)
   ) dut (
      .PCLK        (PCLK),
      .HRESETn     (HRESETn),
      .VSYNC       (VSYNC),
      .HREF        (HREF),
      .START       (START),
      .ABORT       (ABORT),
      .CONT        (CONT),
      .CAP_READY   (CAP_READY),
      .RD_DONE     (RD_DONE),
      .CAP_VALID   (CAP_VALID),
      .BUSY        (BUSY),
      .FRAME_DONE  (FRAME_DONE),
      .TIMEOUT_ERR (TIMEOUT_ERR),
      .LINE_ERR    (LINE_ERR),
      .FRAME_CNT   (FRAME_CNT)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cv"},   CAP_VALID, 0);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_fd"},   FRAME_DONE, 0);
      chk({tag, "_terr"}, TIMEOUT_ERR, 0);
      chk({tag, "_lerr"}, LINE_ERR, 0);
      chk({tag, "_cnt"},  FRAME_CNT, 0);
   endtask

   // Accepted START from IDLE: errors clear, controller busy, not yet capturing.
   task automatic start_req();
      START = 1'b1;
      tick(1);
      START = 1'b0;
      m_terr = 1'b0;
      m_lerr = 1'b0;
      chk("start_busy", BUSY, 1);
      chk("start_terr", TIMEOUT_ERR, m_terr);
      chk("start_lerr", LINE_ERR, m_lerr);
      chk("start_cv",   CAP_VALID, 0);
      $display("start: busy=%0b terr=%0b lerr=%0b", BUSY, TIMEOUT_ERR, LINE_ERR);
   endtask

   // Discarded frames: capture turns on exactly at the SKIPN-th VSYNC edge.
   task automatic skip_frames(input int gap);
      for (int i = 1; i <= SKIPN; i++) begin
         tick(gap);
         VSYNC = 1'b1;
         tick(1);
         chk("skip_cv", CAP_VALID, (i == SKIPN));
         VSYNC = 1'b0;
         tick(1);
      end
      $display("skip: %0d frames, cap_valid=%0b", SKIPN, CAP_VALID);
   endtask

   // One camera frame of `lines` HREF lines, then the datapath reports it held.
   task automatic frame(input int lines);
      VSYNC = 1'b1;
      tick(1);
      VSYNC = 1'b0;
      tick(1);
      for (int l = 0; l < lines; l++) begin
         HREF = 1'b1;
         tick(1);
         HREF = 1'b0;
         tick(1);
      end
      chk("arm_cv", CAP_VALID, 1);
      CAP_READY = 1'b1;
      tick(1);
      m_cnt = m_cnt + 16'd1;
      if (LINE_CHK && (lines != EXPL)) m_lerr = 1'b1;
      chk("frame_done", FRAME_DONE, 1);
      chk("frame_cnt",  FRAME_CNT, m_cnt);
      chk("frame_lerr", LINE_ERR, m_lerr);
      chk("hold_cv",    CAP_VALID, 1);
      tick(1);
      chk("frame_done_1cyc", FRAME_DONE, 0);
      $display("frame: lines=%0d cnt=%0h lerr=%0b", lines, FRAME_CNT, LINE_ERR);
   endtask

   // Consumer finishes, datapath drops CAP_READY; re-arm or go idle on CONT.
   task automatic release_frame(input int rd_wait, input int rdy_wait, input bit cont);
      CONT = cont;
      tick(rd_wait);
      chk("hold_wait_cv", CAP_VALID, 1);
      RD_DONE = 1'b1;
      tick(1);
      RD_DONE = 1'b0;
      chk("rel_cv",   CAP_VALID, 0);
      chk("rel_busy", BUSY, 1);
      tick(rdy_wait);
      chk("rel_wait_cv", CAP_VALID, 0);
      CAP_READY = 1'b0;
      tick(1);
      chk("rel_exit_busy", BUSY, cont);
      chk("rel_exit_cv",   CAP_VALID, cont);
      $display("release: cont=%0b busy=%0b cv=%0b", cont, BUSY, CAP_VALID);
   endtask

   // Cancel from any busy state; CAP_READY is low so the controller then idles.
   task automatic abort_to_idle(input bit with_start_ready);
      ABORT = 1'b1;
      START = with_start_ready;
      CAP_READY = with_start_ready;
      tick(1);
      ABORT = 1'b0;
      START = 1'b0;
      CAP_READY = 1'b0;
      chk("abort_cv",   CAP_VALID, 0);
      chk("abort_busy", BUSY, 1);
      chk("abort_fd",   FRAME_DONE, 0);
      chk("abort_cnt",  FRAME_CNT, m_cnt);
      CONT = 1'b0;
      tick(1);
      chk("abort_idle", BUSY, 0);
      $display("abort: cnt=%0h busy=%0b", FRAME_CNT, BUSY);
   endtask

   initial begin
      // Reset state
      tick(2);
      chk_all_zero("reset");
      HRESETn = 1'b1;
      tick(1);
      chk("post_reset_busy", BUSY, 0);

      // Skip two frames, capture the third, release without CONT
      start_req();
      skip_frames(1);
      frame(LINE_CHK ? EXPL : 8);
      chk("first_cnt", FRAME_CNT, 16'd1);
      release_frame(0, 2, 1'b0);

      // ABORT while idle changes nothing
      ABORT = 1'b1;
      tick(1);
      ABORT = 1'b0;
      chk("idle_abort_busy", BUSY, 0);
      chk("idle_abort_cv", CAP_VALID, 0);

      // Continuous mode: three handshakes, BUSY never drops
      start_req();
      skip_frames(0);
      for (int f = 0; f < 3; f++) begin
         frame(LINE_CHK ? EXPL : 4 + f);
         release_frame($urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
         chk("cont_busy", BUSY, 1);
      end
      chk("cont_cnt", FRAME_CNT, 16'd4);

      // Counter wrap: preload 0xFFFF, one more frame reads 0x0000
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      m_cnt = 16'hFFFF;
      frame(LINE_CHK ? EXPL : 3);
      chk("wrap_cnt", FRAME_CNT, 16'h0000);
      release_frame(1, 1, 1'b0);

      // RD_DONE and START ignored while armed; then START+ABORT+CAP_READY together
      start_req();
      skip_frames(0);
      RD_DONE = 1'b1;
      tick(1);
      RD_DONE = 1'b0;
      chk("arm_rd_ignored", CAP_VALID, 1);
      START = 1'b1;
      tick(1);
      START = 1'b0;
      chk("arm_start_ignored", CAP_VALID, 1);
      abort_to_idle(1'b1);

      // Watchdog: no VSYNC after START expires after exactly TO_CYC cycles
      start_req();
      tick(TO_CYC - 1);
      chk("to_before_terr", TIMEOUT_ERR, 0);
      chk("to_before_busy", BUSY, 1);
      tick(1);
      m_terr = 1'b1;
      chk("to_terr", TIMEOUT_ERR, m_terr);
      chk("to_busy", BUSY, 0);
      chk("to_cv",   CAP_VALID, 0);
      chk("to_cnt",  FRAME_CNT, m_cnt);
      $display("timeout: terr=%0b busy=%0b", TIMEOUT_ERR, BUSY);
      ABORT = 1'b1;
      tick(1);
      ABORT = 1'b0;
      chk("to_sticky", TIMEOUT_ERR, 1);
      start_req();
      abort_to_idle(1'b0);

      // Line count check: one short frame, then a correct frame after restart
      start_req();
      skip_frames(2);
      frame(LINE_CHK ? EXPL - 1 : 5);
      release_frame(0, 0, 1'b0);
      chk("line_err_sticky", LINE_ERR, m_lerr);
      start_req();
      skip_frames(0);
      frame(LINE_CHK ? EXPL : 6);
      chk("line_ok", LINE_ERR, 0);
      release_frame(0, 1, 1'b0);

      // Randomized sessions
      for (int it = 0; it < 10; it++) begin
         int nf;
         start_req();
         skip_frames($urandom_range(0, 4));
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
            int lines;
            if ($urandom_range(0, 5) == 0) begin
               abort_to_idle($urandom_range(0, 1));
               break;
            end
            lines = (LINE_CHK && ($urandom_range(0, 1) == 1)) ? EXPL
                                                              : $urandom_range(0, 15);
            frame(lines);
            release_frame($urandom_range(0, 3), $urandom_range(0, 3), (f != nf - 1));
         end
         chk("rand_idle", BUSY, 0);
         chk("rand_cnt",  FRAME_CNT, m_cnt);
      end

      // Reset in HOLD clears every output without a clock edge
      start_req();
      skip_frames(0);
      frame(2);
      HRESETn = 1'b0;
      #1;
      m_cnt = 16'd0;
      chk_all_zero("hold_reset");
      $display("hold reset: cv=%0b busy=%0b cnt=%0h", CAP_VALID, BUSY, FRAME_CNT);
      @(negedge PCLK);
      CAP_READY = 1'b0;
      HRESETn = 1'b1;
      tick(1);
      chk("after_reset_busy", BUSY, 0);
      chk("after_reset_cnt", FRAME_CNT, m_cnt);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/camera_frame_ctrl.md
CAMERA_FRAME_CTRL -- requirements
Module: camera_frame_ctrl

Interface
REQ-001 SHALL provide parameter SKIP_FRAMES, default 2: VSYNC frames discarded after START before arming capture.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1000000: maximum PCLK cycles without a VSYNC rising edge in SKIP/ARM.
REQ-003 SHALL provide parameter EXP_LINES, default 240: expected HREF lines per frame (line check only).
REQ-004 SHALL have ports PCLK in 1 camera pixel clock; HRESETn in 1 reset. Reset HRESETn, asynchronous, active-low; clock PCLK.
REQ-005 SHALL have VSYNC in 1 and HREF in 1: camera frame and line strobes, synchronous to PCLK.
REQ-006 SHALL have START in 1 (single-cycle request), ABORT in 1 (single-cycle cancel), CONT in 1 (level, continuous re-arm).
REQ-007 SHALL have CAP_READY in 1: frame-held flag from the capture datapath; RD_DONE in 1: single-cycle pulse, consumer finished reading the buffer.
REQ-008 SHALL have CAP_VALID out 1 driving the capture datapath's DATA_VALID; BUSY out 1; FRAME_DONE out 1 pulse.
REQ-009 SHALL have TIMEOUT_ERR out 1 sticky; LINE_ERR out 1 sticky; FRAME_CNT out 16 completed-frame count.

Function
REQ-010 SHALL register VSYNC and HREF once; rising edges SHALL be detected as current & ~registered.
REQ-011 SHALL implement states IDLE, SKIP, ARM, HOLD, RELEASE; BUSY = state != IDLE.
REQ-012 IDLE: on START SHALL clear skip counter, TIMEOUT_ERR and LINE_ERR, then go to SKIP, or to ARM if SKIP_FRAMES = 0.
REQ-013 SKIP: each VSYNC rising edge SHALL increment the skip counter; when the counter reaches SKIP_FRAMES SHALL go to ARM.
REQ-014 ARM: CAP_VALID SHALL be 1; on CAP_READY = 1 SHALL go to HOLD.
REQ-015 On the ARM->HOLD transition FRAME_DONE SHALL pulse high for exactly one cycle and FRAME_CNT SHALL increment, wrapping 0xFFFF->0x0000.
REQ-016 HOLD: CAP_VALID SHALL stay 1; on RD_DONE SHALL drop CAP_VALID in the next cycle and go to RELEASE.
REQ-017 RELEASE: CAP_VALID SHALL be 0; when CAP_READY = 0 SHALL go to ARM if CONT = 1, else to IDLE.
REQ-018 CAP_VALID SHALL be a registered output, high only in ARM and HOLD.
REQ-019 Timeout counter SHALL reset on entry to SKIP or ARM and on every VSYNC rising edge, and count PCLK cycles while in SKIP or ARM.
REQ-020 When the timeout counter reaches TIMEOUT_CYC, SHALL set TIMEOUT_ERR, force CAP_VALID = 0 and go to IDLE.
REQ-021 ABORT in any non-IDLE state SHALL force CAP_VALID = 0 next cycle and go to RELEASE; ABORT in IDLE SHALL have no effect.
REQ-022 ABORT SHALL take priority over START, RD_DONE, timeout and CAP_READY in the same cycle.
REQ-023 START while BUSY SHALL be ignored; RD_DONE outside HOLD SHALL be ignored.
REQ-024 Timeout and ABORT exits SHALL NOT pulse FRAME_DONE or increment FRAME_CNT.
REQ-025 TIMEOUT_ERR and LINE_ERR SHALL clear only on an accepted START or reset.

Reset
REQ-026 On HRESETn low, state SHALL be IDLE; CAP_VALID, BUSY, FRAME_DONE, TIMEOUT_ERR, LINE_ERR SHALL be 0; FRAME_CNT, skip, timeout and line counters SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL drop CAP_VALID immediately (asynchronously); no state SHALL survive reset.

Configuration
REQ-028 Macro CAMFC_LINE_CHECK_EN defined: a 10-bit line counter SHALL clear on each VSYNC rising edge and count HREF rising edges while in ARM.
REQ-029 With CAMFC_LINE_CHECK_EN: on ARM->HOLD, if line count != EXP_LINES, LINE_ERR SHALL be set.
REQ-030 Macro CAMFC_LINE_CHECK_EN undefined: the line counter SHALL be absent and LINE_ERR SHALL be tied 0.

Verification
REQ-031 SKIP_FRAMES=2, START, 3 VSYNC frames -> CAP_VALID rises after the 2nd VSYNC rising edge; CAP_READY=1 -> FRAME_DONE 1 cycle, FRAME_CNT=1.
REQ-032 HOLD, RD_DONE pulse, CAP_READY low 3 cycles later, CONT=0 -> CAP_VALID 0 one cycle after RD_DONE, IDLE after CAP_READY falls, BUSY=0.
REQ-033 CONT=1, 3 full handshakes -> FRAME_CNT=3, BUSY stays 1; FRAME_CNT preset to 0xFFFF then one frame -> 0x0000.
REQ-034 TIMEOUT_CYC=100, START, no VSYNC -> TIMEOUT_ERR=1 at cycle 100, IDLE, CAP_VALID=0; next START clears TIMEOUT_ERR.
REQ-035 START and ABORT in the same cycle in ARM -> RELEASE, CAP_VALID=0, FRAME_CNT unchanged; HRESETn low in HOLD -> all outputs 0.
REQ-036 With CAMFC_LINE_CHECK_EN, EXP_LINES=240, 239 HREF pulses then CAP_READY -> LINE_ERR=1; 240 pulses -> LINE_ERR=0.
